// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types, widths and saturation helper for the multiplier datapath
// Purpose: constants and helpers shared by mult, mult_accumulator and the tester.
// Contents:
//   PROD_W    width of the signed product produced by mult
//   SAT_W     working width used by sat_add (accumulators up to SAT_W-1 bits)
//   state_e   accumulator frame state
//   sat_e     saturation outcome of an addition
//   sat_add   classify a + b against a signed w-bit range
package mult_pkg;

  localparam int PROD_W = 16;
  localparam int SAT_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  // Operands arrive sign-extended to SAT_W, so the sum cannot wrap for any
  // w below SAT_W; the caller substitutes max/min when told to.
  function automatic sat_e sat_add(input logic signed [SAT_W-1:0] a,
                                   input logic signed [SAT_W-1:0] b,
                                   input int w);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] mx;
    logic signed [SAT_W-1:0] mn;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (s > mx) begin
      return SAT_HI;
    end else if (s < mn) begin
      return SAT_LO;
    end
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/done_edge_det.sv
// rtl/done_edge_det.sv - rising-edge detector for the mult done level
// Purpose: one-cycle capture strobe on each rising edge of done.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   done  in   done level from mult
//   cap   out  high for the cycle in which done first reads high
module done_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic done,
  output logic cap
);

  logic done_q;

  // Resets to 1 so a done already high when reset releases is not a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b1;
    end else begin
      done_q <= done;
    end
  end

  assign cap = done & ~done_q;

endmodule

// File: rtl/mult_accumulator.sv
// rtl/mult_accumulator.sv - saturating frame accumulator of mult products
// Purpose: sums FRAME_LEN signed products into a saturating ACC_W-bit
//   accumulator and holds the frame result until acknowledged.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   r          in   signed product from mult
//   done       in   mult done level; rising edge marks a new valid r
//   clear      in   synchronous abort: discard frame, clear flags
//   ack        in   consumer accepted the frame result
//   acc        out  signed running/frame sum
//   count      out  products accumulated in current frame
//   acc_valid  out  frame complete, acc frozen
//   overflow   out  sticky saturation flag for this frame
//   dropped    out  sticky flag: a product arrived while full
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 4,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PROD_W-1:0]       r,
  input  logic                    done,
  input  logic                    clear,
  input  logic                    ack,
  output logic signed [ACC_W-1:0] acc,
  output logic [CNT_W-1:0]        count,
  output logic                    acc_valid,
  output logic                    overflow,
  output logic                    dropped
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic cap;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    drop_q, drop_d;

  logic signed [ACC_W-1:0] r_ext;
  logic signed [SAT_W-1:0] acc_wide;
  logic signed [SAT_W-1:0] r_wide;
  logic [CNT_W-1:0]        count_inc;
  sat_e                    sat;

  done_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .done (done),
    .cap  (cap)
  );

  assign r_ext     = {{(ACC_W-PROD_W){r[PROD_W-1]}}, r};
  assign acc_wide  = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign r_wide    = {{(SAT_W-PROD_W){r[PROD_W-1]}}, r};
  assign count_inc = count_q + CNT_ONE;
  assign sat       = sat_add(acc_wide, r_wide, ACC_W);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (clear) begin
      // A capture in the same cycle is discarded with the frame.
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      drop_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cap) begin
            acc_d   = r_ext;
            count_d = CNT_ONE;
            if (FRAME_LEN == 1) begin
              state_d = FULL;
              valid_d = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (cap) begin
            count_d = count_inc;
            unique case (sat)
              SAT_HI: begin
                acc_d = ACC_MAX;
                ovf_d = 1'b1;
              end
              SAT_LO: begin
                acc_d = ACC_MIN;
                ovf_d = 1'b1;
              end
              default: acc_d = acc_q + r_ext;
            endcase
            if (count_inc == FRAME_CNT) begin
              state_d = FULL;
              valid_d = 1'b1;
            end
          end
        end
        FULL: begin
          // ack outranks a coincident capture: frame released, product dropped silently.
          if (ack) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
          end else if (cap) begin
            drop_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign acc       = acc_q;
  assign count     = count_q;
  assign acc_valid = valid_q;
  assign overflow  = ovf_q;
  assign dropped   = drop_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// tb/tb_mult_accumulator.sv - self-checking bench for mult_accumulator (ACC_W 24 and 17)
module tb_mult_accumulator;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] r;
  logic        done;
  logic        clear;
  logic        ack;

  logic signed [23:0] acc_a;
  logic [2:0]         count_a;
  logic               valid_a, ovf_a, drop_a;
  logic signed [16:0] acc_b;
  logic [2:0]         count_b;
  logic               valid_b, ovf_b, drop_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_accumulator #(.ACC_W(24), .FRAME_LEN(FL)) dut_a (
    .clk(clk), .rst(rst), .r(r), .done(done), .clear(clear), .ack(ack),
    .acc(acc_a), .count(count_a), .acc_valid(valid_a), .overflow(ovf_a), .dropped(drop_a)
  );

  mult_accumulator #(.ACC_W(17), .FRAME_LEN(FL)) dut_b (
    .clk(clk), .rst(rst), .r(r), .done(done), .clear(clear), .ack(ack),
    .acc(acc_b), .count(count_b), .acc_valid(valid_b), .overflow(ovf_b), .dropped(drop_b)
  );

  // Behavioural model, one entry per DUT: [0] ACC_W=24, [1] ACC_W=17.
  int     m_w[2]     = '{24, 17};
  longint m_acc[2]   = '{0, 0};
  int     m_cnt[2]   = '{0, 0};
  bit     m_valid[2] = '{0, 0};
  bit     m_ovf[2]   = '{0, 0};
  bit     m_drop[2]  = '{0, 0};
  bit     m_prev     = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
      end
    end else begin
      bit     edge_seen;
      longint s, hi, lo;
      edge_seen = done && !m_prev;
      m_prev = done;
      for (int i = 0; i < 2; i++) begin
        if (clear) begin
          m_acc[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
        end else if (m_valid[i]) begin
          if (ack) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
          end else if (edge_seen) begin
            m_drop[i] = 1;
          end
        end else if (edge_seen) begin
          hi = (longint'(1) << (m_w[i] - 1)) - 1;
          lo = -hi - 1;
          s  = m_acc[i] + longint'($signed(r));
          if (s > hi) begin s = hi; m_ovf[i] = 1; end
          if (s < lo) begin s = lo; m_ovf[i] = 1; end
          m_acc[i] = s;
          m_cnt[i]++;
          if (m_cnt[i] == FL) m_valid[i] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("acc_a", longint'(acc_a), m_acc[0]);
    chk("count_a", longint'(count_a), longint'(m_cnt[0]));
    chk("valid_a", longint'(valid_a), longint'(m_valid[0]));
    chk("ovf_a", longint'(ovf_a), longint'(m_ovf[0]));
    chk("drop_a", longint'(drop_a), longint'(m_drop[0]));
    chk("acc_b", longint'(acc_b), m_acc[1]);
    chk("count_b", longint'(count_b), longint'(m_cnt[1]));
    chk("valid_b", longint'(valid_b), longint'(m_valid[1]));
    chk("ovf_b", longint'(ovf_b), longint'(m_ovf[1]));
    chk("drop_b", longint'(drop_b), longint'(m_drop[1]));
  end

  // Capture happens on the second posedge; returns with outputs already updated.
  task automatic pulse(input logic [15:0] v);
    @(posedge clk); #1;
    r = v; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic do_ack();
    @(posedge clk); #1; ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; r = '0; done = 1'b1; clear = 1'b0; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: done high through reset release is not a capture
    repeat (5) @(posedge clk);
    #1;
    chk("t1_count", longint'(count_a), 0);
    chk("t1_valid", longint'(valid_a), 0);
    chk("t1_acc", longint'(acc_a), 0);
    done = 1'b0;

    // 2: frame 15, -6, 100, -1 = 108
    pulse(16'd15); pulse(16'hFFFA); pulse(16'd100);
    chk("t2_valid_early", longint'(valid_a), 0);
    chk("t2_count3", longint'(count_a), 3);
    pulse(16'hFFFF);
    chk("t2_acc", longint'(acc_a), 108);
    chk("t2_count", longint'(count_a), 4);
    chk("t2_valid", longint'(valid_a), 1);
    chk("t2_ovf", longint'(ovf_a), 0);

    // 4: product in FULL dropped, then ack
    pulse(16'd7);
    chk("t4_acc_frozen", longint'(acc_a), 108);
    chk("t4_dropped", longint'(drop_a), 1);
    do_ack();
    chk("t4_acc", longint'(acc_a), 0);
    chk("t4_count", longint'(count_a), 0);
    chk("t4_valid", longint'(valid_a), 0);
    chk("t4_dropped_clr", longint'(drop_a), 0);

    // 3: saturation at ACC_W=17, none at 24
    repeat (4) pulse(16'h4000);
    chk("t3_acc17", longint'(acc_b), 65535);
    chk("t3_ovf17", longint'(ovf_b), 1);
    chk("t3_acc24", longint'(acc_a), 65536);
    chk("t3_ovf24", longint'(ovf_a), 0);
    do_ack();
    chk("t3_ovf_clr", longint'(ovf_b), 0);
    repeat (4) pulse(16'hC080);
    chk("t3_neg17", longint'(acc_b), -65024);
    chk("t3_neg_ovf17", longint'(ovf_b), 0);
    do_ack();

    // 5: clear with coincident capture discards frame
    pulse(16'd10); pulse(16'd10);
    chk("t5_acc20", longint'(acc_a), 20);
    @(posedge clk); #1;
    r = 16'd5; done = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; done = 1'b0;
    chk("t5_acc", longint'(acc_a), 0);
    chk("t5_count", longint'(count_a), 0);
    pulse(16'd1); pulse(16'd2); pulse(16'd3); pulse(16'd4);
    chk("t5_fresh", longint'(acc_a), 10);
    chk("t5_fresh_valid", longint'(valid_a), 1);
    do_ack();

    // 6: async reset mid-frame
    pulse(16'd1); pulse(16'd2); pulse(16'd3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_acc_async", longint'(acc_a), 0);
    chk("t6_count_async", longint'(count_a), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulse(16'd50); pulse(16'hFFEC); pulse(16'd7); pulse(16'd3);
    chk("t6_acc", longint'(acc_a), 40);
    chk("t6_valid", longint'(valid_a), 1);
    do_ack();
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
